// File: rtl/add_sub_acc.sv
`default_nettype none
// ============================================================================
//  Module      : add_sub_acc
//  Description : Command-driven accumulator stage. Each accepted command adds
//                or subtracts an operand into a registered accumulator, or
//                clears it. Results are returned over a valid/ready handshake
//                with carry/no-borrow, signed overflow, a sticky overflow
//                flag and an add/sub operation counter.
//  Revision    : 1.0  initial release
// ============================================================================
module add_sub_acc #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_mode,
   input  logic             in_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_acc,
   output logic             out_carry,
   output logic             out_ovf,
   output logic             out_ovf_sticky,
   output logic [CNT_W-1:0] out_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next;

   logic [WIDTH-1:0]   r_cmd_data;
   logic               r_cmd_mode;
   logic               r_cmd_clr;

   logic [WIDTH-1:0]   r_acc;
   logic               r_carry;
   logic               r_ovf;
   logic               r_sticky;
   logic [CNT_W-1:0]   r_count;

   logic               w_accept;
   logic [WIDTH-1:0]   w_b_eff;
   logic [WIDTH:0]     w_sum;
   logic               w_ovf;

   // Handshake decode is taken from registered state only; rst masks ready.
   assign in_ready  = (r_state == S_IDLE) & ~rst;
   assign out_valid = (r_state == S_DONE);
   assign w_accept  = in_valid & in_ready;

   // Subtraction is ACC + ~B + 1; the +1 enters as the carry-in term.
   assign w_b_eff = r_cmd_mode ? ~r_cmd_data : r_cmd_data;
   assign w_sum   = {1'b0, r_acc} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, r_cmd_mode};
   // Overflow: both addends share a sign and the result sign differs from it.
   assign w_ovf   = (r_acc[WIDTH-1] == w_b_eff[WIDTH-1]) &
                    (w_sum[WIDTH-1] != r_acc[WIDTH-1]);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state: accept in IDLE, one cycle of EXEC, hold DONE until consumed.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept)  w_next = S_EXEC;
         S_EXEC:                 w_next = S_DONE;
         S_DONE:  if (out_ready) w_next = S_IDLE;
         default:                w_next = S_IDLE;
      endcase
   end

   // Command register: operands captured only on the accepting edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cmd_data <= '0;
         r_cmd_mode <= 1'b0;
         r_cmd_clr  <= 1'b0;
      end else if (w_accept) begin
         r_cmd_data <= in_data;
         r_cmd_mode <= in_mode;
         r_cmd_clr  <= in_clr;
      end
   end

   // Accumulator, flags and counter update at the EXEC -> DONE edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc    <= '0;
         r_carry  <= 1'b0;
         r_ovf    <= 1'b0;
         r_sticky <= 1'b0;
         r_count  <= '0;
      end else if (r_state == S_EXEC) begin
         if (r_cmd_clr) begin
            r_acc    <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_sticky <= 1'b0;
            r_count  <= '0;
         end else begin
            r_acc    <= w_sum[WIDTH-1:0];
            r_carry  <= w_sum[WIDTH];
            r_ovf    <= w_ovf;
            r_sticky <= r_sticky | w_ovf;
            r_count  <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign out_acc        = r_acc;
   assign out_carry      = r_carry;
   assign out_ovf        = r_ovf;
   assign out_ovf_sticky = r_sticky;
   assign out_count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_add_sub_acc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_add_sub_acc
//  Description : Self-checking bench for add_sub_acc with an arithmetic
//                reference model, directed corner cases and random commands.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_add_sub_acc;

   localparam int W  = 4;
   localparam int CW = 8;
   localparam int MOD  = 1 << W;
   localparam int CMOD = 1 << CW;
   localparam int HALF = 1 << (W - 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic          in_mode = 1'b0;
   logic          in_clr = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_acc;
   logic          out_carry;
   logic          out_ovf;
   logic          out_ovf_sticky;
   logic [CW-1:0] out_count;

   int tests = 0;
   int fails = 0;

   // reference model state
   int m_acc = 0, m_carry = 0, m_ovf = 0, m_sticky = 0, m_cnt = 0;

   add_sub_acc #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_mode(in_mode), .in_clr(in_clr),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_acc(out_acc), .out_carry(out_carry), .out_ovf(out_ovf),
      .out_ovf_sticky(out_ovf_sticky), .out_count(out_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int sgn(input int v);
      return (v >= HALF) ? v - MOD : v;
   endfunction

   task automatic model_reset();
      m_acc = 0; m_carry = 0; m_ovf = 0; m_sticky = 0; m_cnt = 0;
   endtask

   // Plain integer arithmetic: carry from magnitude, overflow from signed range.
   task automatic model_apply(input bit mode, input bit clr, input int b);
      int r;
      if (clr) begin
         model_reset();
      end else begin
         if (!mode) begin
            m_carry = (m_acc + b >= MOD) ? 1 : 0;
            r       = sgn(m_acc) + sgn(b);
            m_acc   = (m_acc + b) % MOD;
         end else begin
            m_carry = (m_acc >= b) ? 1 : 0;
            r       = sgn(m_acc) - sgn(b);
            m_acc   = (m_acc - b + MOD) % MOD;
         end
         m_ovf    = (r > HALF - 1 || r < -HALF) ? 1 : 0;
         m_sticky = m_sticky | m_ovf;
         m_cnt    = (m_cnt + 1) % CMOD;
      end
   endtask

   // Compare process: every cycle a result is presented it must match the model.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         chk("mon_acc",    out_acc,        m_acc);
         chk("mon_carry",  out_carry,      m_carry);
         chk("mon_ovf",    out_ovf,        m_ovf);
         chk("mon_sticky", out_ovf_sticky, m_sticky);
         chk("mon_count",  out_count,      m_cnt);
      end
   end

   // One full command: accept, check 2-edge latency, optional backpressure, consume.
   task automatic do_cmd(input bit mode, input bit clr, input logic [W-1:0] d, input int hold);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("ready_timeout", 0, 1);
         return;
      end
      in_valid  = 1'b1;
      in_mode   = mode;
      in_clr    = clr;
      in_data   = d;
      out_ready = (hold == 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = W'($urandom);
      in_mode  = 1'($urandom);
      in_clr   = 1'($urandom);
      model_apply(mode, clr, int'(d));
      @(negedge clk);
      chk("exec_valid_low", out_valid, 0);
      chk("exec_ready_low", in_ready, 0);
      @(negedge clk);
      chk("latency_valid", out_valid, 1);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom);
         in_data  = W'($urandom);
         @(negedge clk);
         chk("bp_ready_low", in_ready, 0);
         chk("bp_valid_held", out_valid, 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("consumed_valid_low", out_valid, 0);
      chk("consumed_ready_high", in_ready, 1);
   endtask

   initial begin
      // Reset with in_valid held high
      in_valid = 1'b1;
      in_data  = 4'b0101;
      repeat (3) @(negedge clk);
      chk("rst_ready", in_ready, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_acc", out_acc, 0);
      chk("rst_flags", {out_carry, out_ovf, out_ovf_sticky}, 0);
      chk("rst_count", out_count, 0);
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("rel_ready", in_ready, 1);
      repeat (2) @(negedge clk);
      chk("rel_no_cmd_valid", out_valid, 0);
      chk("rel_no_cmd_count", out_count, 0);

      // Directed sequence from ACC=0
      do_cmd(1'b0, 1'b0, 4'b1101, 0);
      chk("d1_acc", out_acc, 4'b1101);
      chk("d1_cv", {out_carry, out_ovf}, 2'b00);
      do_cmd(1'b0, 1'b0, 4'b1111, 0);
      chk("d2_acc", out_acc, 4'b1100);
      chk("d2_cv", {out_carry, out_ovf}, 2'b10);
      do_cmd(1'b1, 1'b0, 4'b0011, 0);
      chk("d3_acc", out_acc, 4'b1001);
      chk("d3_cv", {out_carry, out_ovf}, 2'b10);
      do_cmd(1'b0, 1'b0, 4'b1000, 0);
      chk("d4_acc", out_acc, 4'b0001);
      chk("d4_cvs", {out_carry, out_ovf, out_ovf_sticky}, 3'b111);
      chk("d4_count", out_count, 4);

      // Subtract corners
      do_cmd(1'b0, 1'b1, 4'b0000, 0);
      do_cmd(1'b1, 1'b0, 4'b0001, 0);
      chk("s0_acc", out_acc, 4'b1111);
      chk("s0_cv", {out_carry, out_ovf}, 2'b00);
      do_cmd(1'b0, 1'b1, 4'b0000, 0);
      do_cmd(1'b0, 1'b0, 4'b1000, 0);
      do_cmd(1'b1, 1'b0, 4'b0001, 0);
      chk("s8_acc", out_acc, 4'b0111);
      chk("s8_cv", {out_carry, out_ovf}, 2'b11);

      // Backpressure: result held, no extra commands
      do_cmd(1'b0, 1'b0, 4'b0010, 5);
      chk("bp_acc", out_acc, 4'b1001);
      chk("bp_count", out_count, 3);

      // Clear after sticky overflow, then counter/accumulator wrap
      do_cmd(1'b0, 1'b1, 4'b1010, 0);
      chk("clr_acc", out_acc, 0);
      chk("clr_flags", {out_carry, out_ovf, out_ovf_sticky}, 0);
      chk("clr_count", out_count, 0);
      for (int i = 0; i < 256; i++) do_cmd(1'b0, 1'b0, 4'b0001, 0);
      chk("wrap_count", out_count, 0);
      chk("wrap_acc", out_acc, 0);

      // Reset mid-EXEC
      do_cmd(1'b0, 1'b0, 4'b0110, 0);
      in_valid = 1'b1; in_mode = 1'b0; in_clr = 1'b0; in_data = 4'b0011;
      @(posedge clk); #1; in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      model_reset();
      chk("rexec_valid", out_valid, 0);
      chk("rexec_acc", out_acc, 0);
      chk("rexec_ready", in_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      do_cmd(1'b0, 1'b0, 4'b0011, 0);
      chk("rexec_after_acc", out_acc, 4'b0011);
      chk("rexec_after_cnt", out_count, 1);

      // Reset mid-DONE
      in_valid = 1'b1; in_mode = 1'b0; in_clr = 1'b0; in_data = 4'b0100; out_ready = 1'b0;
      @(posedge clk); #1; in_valid = 1'b0;
      model_apply(1'b0, 1'b0, 4);
      repeat (2) @(negedge clk);
      chk("rdone_valid_pre", out_valid, 1);
      rst = 1'b1;
      #1;
      model_reset();
      chk("rdone_valid", out_valid, 0);
      chk("rdone_acc", out_acc, 0);
      @(negedge clk);
      rst = 1'b0;
      do_cmd(1'b1, 1'b0, 4'b0001, 0);
      chk("rdone_after_acc", out_acc, 4'b1111);
      chk("rdone_after_cnt", out_count, 1);

      // Random commands against the model
      for (int i = 0; i < 300; i++) begin
         do_cmd(1'($urandom), ($urandom_range(0, 15) == 0), W'($urandom),
                int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1);
   end

endmodule
`default_nettype wire
